// File: rtl/enc_event_fifo.sv
// rtl/enc_event_fifo.sv - event detector and first-word-fall-through queue behind the 4-to-2 encoder
//
// Purpose:
//   Samples the encoder's index/valid pair every cycle. A new event is either a
//   rising edge of valid, or a change of index while valid stays high. The index
//   of each event is stored in a small FWFT FIFO and offered to a consumer over
//   a valid/ready handshake. Events that find the FIFO full (and not popping in
//   the same cycle) are counted in a saturating drop counter instead of stored.
//
// Parameters:
//   DEPTH     FIFO entries (power of two, >= 2)
//   CNT_W     width of the saturating drop counter
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   in_y       encoder index output
//   in_v       encoder valid output
//   out_y      index at FIFO head, 2'b00 when empty
//   out_valid  head entry available
//   out_ready  consumer accepts head this cycle
//   count      number of stored entries, 0..DEPTH
//   full       count == DEPTH
//   empty      count == 0
//   drop_cnt   events lost to a full FIFO, saturates at all-ones

module enc_event_fifo #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0]               in_y,
  input  logic                     in_v,
  output logic [1:0]               out_y,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic [CNT_W-1:0]         drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [1:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [1:0]    prev_y;
  logic          prev_v;

  logic evt;
  logic pop;
  logic push;
  logic drop;

  // Status flags come only from the registered count, so nothing on in_*
  // reaches an output within the same cycle.
  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign out_valid = !empty;

  // Head is forced to zero when empty so stale array contents never leak out.
  assign out_y = empty ? 2'b00 : mem[rd_ptr];

  // A held input produces one event; in_v=0 never does.
  assign evt  = in_v && (!prev_v || (in_y != prev_y));
  assign pop  = out_valid && out_ready;
  // When full, a same-cycle pop frees the slot the new entry needs.
  assign push = evt && (!full || pop);
  assign drop = evt && full && !pop;

  // Array storage is not reset; pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem[wr_ptr] <= in_y;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      drop_cnt <= '0;
      prev_y   <= 2'b00;
      prev_v   <= 1'b0;
    end else begin
      prev_y <= in_y;
      prev_v <= in_v;

      // Pointers wrap naturally because DEPTH is a power of two.
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end

      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      if (drop && (drop_cnt != '1)) begin
        drop_cnt <= drop_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_enc_event_fifo.sv
// tb/tb_enc_event_fifo.sv - self-checking bench for enc_event_fifo against a queue model

module tb_enc_event_fifo;

  localparam int DEPTH = 4;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [1:0]       in_y = 2'b00;
  logic             in_v = 1'b0;
  logic             out_ready = 1'b0;
  logic [1:0]       out_y;
  logic             out_valid;
  logic [2:0]       count;
  logic             full;
  logic             empty;
  logic [CNT_W-1:0] drop_cnt;

  int n_checks = 0;
  int n_err    = 0;

  enc_event_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_y      (in_y),
    .in_v      (in_v),
    .out_y     (out_y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a queue of indices, a drop tally and the last sample.
  int         mq[$];
  int         m_drops = 0;
  logic       m_pv = 1'b0;
  logic [1:0] m_py = 2'b00;
  bit         started = 1'b0;

  always @(posedge clk) begin
    bit ev;
    bit pp;
    if (rst) begin
      mq.delete();
      m_drops = 0;
      m_pv = 1'b0;
      m_py = 2'b00;
      started = 1'b1;
    end else begin
      ev = in_v && (!m_pv || in_y != m_py);
      pp = (mq.size() > 0) && out_ready;
      if (pp) void'(mq.pop_front());
      if (ev) begin
        if (mq.size() < DEPTH) mq.push_back(int'(in_y));
        else if (m_drops < (1 << CNT_W) - 1) m_drops++;
      end
      m_pv = in_v;
      m_py = in_y;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("model_count", int'(count), mq.size());
      check("model_empty", int'(empty), int'(mq.size() == 0));
      check("model_full", int'(full), int'(mq.size() == DEPTH));
      check("model_valid", int'(out_valid), int'(mq.size() > 0));
      check("model_out_y", int'(out_y), (mq.size() > 0) ? mq[0] : 0);
      check("model_drops", int'(drop_cnt), m_drops);
    end
  end

  // Drive at the falling edge, then return shortly after the rising edge.
  task automatic cyc(input logic r, input logic v, input logic [1:0] y, input logic rdy);
    @(negedge clk);
    rst = r;
    in_v = v;
    in_y = y;
    out_ready = rdy;
    @(posedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [1:0] exp_a [4];

    // Reset for two cycles.
    cyc(1, 0, 2'b00, 0);
    cyc(1, 0, 2'b00, 0);
    check("rst_count", int'(count), 0);
    check("rst_empty", int'(empty), 1);
    check("rst_full", int'(full), 0);
    check("rst_valid", int'(out_valid), 0);
    check("rst_out_y", int'(out_y), 0);
    check("rst_drop", int'(drop_cnt), 0);

    // Held input gives a single event, visible one cycle after sampling.
    cyc(0, 1, 2'b10, 0);
    check("t1_valid", int'(out_valid), 1);
    check("t1_out_y", int'(out_y), 2);
    for (int i = 0; i < 4; i++) cyc(0, 1, 2'b10, 0);
    check("t1_count", int'(count), 1);
    cyc(0, 0, 2'b00, 1);
    check("t1_drained", int'(empty), 1);

    // Index change while valid is held.
    cyc(0, 1, 2'b00, 0);
    cyc(0, 1, 2'b01, 0);
    cyc(0, 1, 2'b11, 0);
    check("t2_count", int'(count), 3);
    exp_a[0] = 2'b00; exp_a[1] = 2'b01; exp_a[2] = 2'b11;
    for (int i = 0; i < 3; i++) begin
      check("t2_pop_y", int'(out_y), int'(exp_a[i]));
      cyc(0, 0, 2'b00, 1);
    end
    check("t2_empty", int'(empty), 1);
    check("t2_out_y", int'(out_y), 0);

    // Overflow with saturating drop counter (CNT_W=2 saturates at 3).
    for (int i = 0; i < 8; i++) begin
      cyc(0, 1, (i % 2 == 0) ? 2'b00 : 2'b01, 0);
      if (i == 3) check("t3_full", int'(full), 1);
    end
    check("t3_drop_sat", int'(drop_cnt), 3);
    check("t3_count", int'(count), 4);
    for (int i = 0; i < 4; i++) begin
      check("t3_order", int'(out_y), (i % 2 == 0) ? 0 : 1);
      cyc(0, 0, 2'b00, 1);
    end

    // Full with simultaneous pop: accepted, no drop.
    cyc(1, 0, 2'b00, 0);
    cyc(0, 1, 2'b01, 0);
    cyc(0, 1, 2'b10, 0);
    cyc(0, 1, 2'b11, 0);
    cyc(0, 1, 2'b00, 0);
    check("t4_full", int'(full), 1);
    cyc(0, 1, 2'b10, 1);
    check("t4_count", int'(count), 4);
    check("t4_drop", int'(drop_cnt), 0);
    exp_a[0] = 2'b10; exp_a[1] = 2'b11; exp_a[2] = 2'b00; exp_a[3] = 2'b10;
    for (int i = 0; i < 4; i++) begin
      check("t4_order", int'(out_y), int'(exp_a[i]));
      cyc(0, 0, 2'b00, 1);
    end
    check("t4_empty", int'(empty), 1);

    // Streaming across pointer wrap: each index out one cycle later.
    for (int i = 0; i < 20; i++) begin
      cyc(0, 1, 2'(i), 1);
      check("t5_count", int'(count), 1);
      check("t5_out_y", int'(out_y), i % 4);
    end
    cyc(0, 0, 2'b00, 1);
    check("t5_empty", int'(empty), 1);

    // Reset mid-operation with in_v held.
    for (int i = 0; i < 6; i++) cyc(0, 1, (i % 2 == 0) ? 2'b01 : 2'b10, 0);
    cyc(0, 1, 2'b10, 1);
    check("t6_pre_count", int'(count), 3);
    check("t6_pre_drop", int'(drop_cnt), 2);
    cyc(1, 1, 2'b11, 0);
    check("t6_rst_count", int'(count), 0);
    check("t6_rst_drop", int'(drop_cnt), 0);
    check("t6_rst_valid", int'(out_valid), 0);
    cyc(0, 1, 2'b11, 0);
    check("t6_new_count", int'(count), 1);
    check("t6_new_y", int'(out_y), 3);
    cyc(0, 1, 2'b11, 0);
    check("t6_held_count", int'(count), 1);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
